bru_predict: RTL and testbench
==============================

BRU_PREDICT -- requirements
Module: bru_predict

Interface
REQ-001 The block SHALL have parameter BHT_ENTRIES, default 64, meaning the number of 2-bit direction counters; the value is a power of 2 and at least 4.
REQ-002 The block SHALL have parameter BHT_IDX_W, default $clog2(BHT_ENTRIES), meaning the index width; it is derived and never overridden.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 flush_i  input  1  pipeline flush.
REQ-006 lookup_pc_i  input  32  fetch PC for prediction lookup.
REQ-007 lookup_taken_o  output  1  predicted direction, combinational: MSB of BHT[lookup_pc_i[BHT_IDX_W+1:2]].
REQ-008 issue_valid_i  input  1  issue strobe.
REQ-009 entry_i  input  rs_entry_t  issued entry; uses valid, pc, imm, funct3, instr, is_branch, is_jump, is_jalr, rd_used, prd, rob_tag.
REQ-010 src1_i / src2_i  input  xlen_t  operands.
REQ-011 pred_taken_i  input  1  direction predicted at fetch for this entry.
REQ-012 pred_target_i  input  32  target predicted at fetch; ignored when pred_taken_i=0.
REQ-013 mispredict_o  output  1  registered recovery request.
REQ-014 target_pc_o  output  32  registered correct next PC.
REQ-015 recover_tag_o  output  ROB_W  registered ROB tag of the mispredicted instruction.
REQ-016 wb_o  output  wb_pkt_t  registered writeback packet.
REQ-017 perf_br_cnt_o / perf_mp_cnt_o  output  32 each  resolved-branch count and mispredict count.

Function
REQ-018 "Resolve" SHALL mean issue_valid_i && entry_i.valid && !flush_i at a posedge; all outputs appear 1 cycle later and hold for exactly 1 cycle unless another resolve occurs.
REQ-019 Jumps (is_jump, or opcode 1101111/1100111) SHALL be actual-taken; the JAL target is pc+imm, and the JALR target is (src1+imm)&~1.
REQ-020 Conditional branches SHALL decide direction by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; other codes are not-taken; the target is pc+imm.
REQ-021 The correct next PC SHALL be the taken target if actual-taken, else pc+4 (32-bit wrap).
REQ-022 Mispredict SHALL be (actual != pred_taken_i) || (actual && pred_taken_i && target != pred_target_i); on mispredict, target_pc_o = correct next PC and recover_tag_o = entry_i.rob_tag.
REQ-023 When there is no mispredict, mispredict_o, target_pc_o and recover_tag_o SHALL be 0.
REQ-024 On every resolve, wb_o SHALL have valid=1, rob_tag, rd_used, prd (0 if !rd_used), and data = pc+4 for jumps with rd_used, else 0.
REQ-025 A resolve of a conditional branch SHALL update counter BHT[pc[BHT_IDX_W+1:2]] with 2-bit saturation: +1 if taken (saturate at 3), -1 if not taken (saturate at 0).
REQ-026 A jump resolve SHALL NOT update the BHT.
REQ-027 A lookup and an update to the same index in the same cycle SHALL return the pre-update value (no bypass).
REQ-028 flush_i=1 SHALL clear all registered outputs at the next edge, and the issue in that cycle SHALL neither update the BHT nor the counters; BHT contents otherwise survive flush.

Reset
REQ-029 With rst_n=0 at a posedge, all outputs SHALL be cleared to 0 and every BHT counter set to 01 (weakly not-taken).
REQ-030 Reset SHALL take priority over flush_i and resolve; a resolve in a reset cycle is discarded.
REQ-031 lookup_taken_o SHALL read 0 for all PCs after reset.

Configuration
REQ-032 With macro BRU_PERF_CNT_EN defined, perf_br_cnt_o SHALL increment on each conditional-branch resolve, and perf_mp_cnt_o SHALL increment on each resolve that sets mispredict (branches or jumps).
REQ-033 Both counters SHALL saturate at 0xFFFF_FFFF, are cleared by reset, and are not cleared by flush.
REQ-034 Without BRU_PERF_CNT_EN, both counter outputs SHALL be constant 0 and no counter flops exist.

Verification
REQ-035 Reset, then lookup_pc_i=0x100 -> lookup_taken_o=0; all outputs 0.
REQ-036 BEQ pc=0x100 imm=0x20 src1=src2=5 pred_taken=0 -> next cycle mispredict_o=1, target_pc_o=0x120, recover_tag_o=entry tag, wb_o.valid=1; the following cycle mispredict_o=0.
REQ-037 Repeat the REQ-036 branch 3 times taken -> lookup of 0x100 returns 1 after the first update (counter 01->10) and the counter saturates at 11; 3 not-taken resolves -> returns 0.
REQ-038 BNE pc=0x200 src1=src2 pred_taken=1 pred_target=0x240 -> mispredict_o=1, target_pc_o=0x204.
REQ-039 JALR pc=0x300 src1=0x1001 imm=4 rd_used=1 pred_taken=1 pred_target=0x1004 -> mispredict_o=0, wb_o.data=0x304, BHT unchanged.
REQ-040 Resolve with flush_i=1 in the same cycle -> next cycle all outputs 0, BHT and perf counters unchanged; with BRU_PERF_CNT_EN, REQ-036 ends with perf_br_cnt_o=1 and perf_mp_cnt_o=1.

Source files
------------

// File: rtl/bru_predict.sv
// Branch resolution unit with a 2-bit BHT direction predictor.
// Optional macro BRU_PERF_CNT_EN adds saturating resolved-branch / mispredict counters.
package bru_pkg;
  localparam int XLEN  = 32;
  localparam int ROB_W = 6;
  localparam int PRD_W = 6;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [2:0]        funct3;
    logic [31:0]       instr;
    logic              is_branch;
    logic              is_jump;
    logic              is_jalr;
    logic              rd_used;
    logic [PRD_W-1:0]  prd;
    logic [ROB_W-1:0]  rob_tag;
  } rs_entry_t;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob_tag;
    logic              rd_used;
    logic [PRD_W-1:0]  prd;
    xlen_t             data;
  } wb_pkt_t;
endpackage

module bru_predict
  import bru_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              lookup_taken_o,
  input  logic              issue_valid_i,
  input  rs_entry_t         entry_i,
  input  xlen_t             src1_i,
  input  xlen_t             src2_i,
  input  logic              pred_taken_i,
  input  logic [31:0]       pred_target_i,
  output logic              mispredict_o,
  output logic [31:0]       target_pc_o,
  output logic [ROB_W-1:0]  recover_tag_o,
  output wb_pkt_t           wb_o,
  output logic [31:0]       perf_br_cnt_o,
  output logic [31:0]       perf_mp_cnt_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0] bht [BHT_ENTRIES];

  logic [6:0]           opcode;
  logic                 is_jalr;
  logic                 is_jmp;
  logic                 is_cond;
  logic                 cond_taken;
  logic                 actual_taken;
  logic [31:0]          taken_target;
  logic [31:0]          seq_pc;
  logic [31:0]          next_pc;
  logic                 mispredict;
  logic                 resolve;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic                 unused_bits;

  assign unused_bits = ^{lookup_pc_i, entry_i.instr};

  // Lookup reads the array directly, so a same-cycle update is never bypassed.
  assign lookup_idx     = lookup_pc_i[BHT_IDX_W+1:2];
  assign lookup_taken_o = bht[lookup_idx][1];

  assign opcode  = entry_i.instr[6:0];
  assign is_jalr = entry_i.is_jalr || (opcode == OP_JALR);
  assign is_jmp  = entry_i.is_jump || is_jalr || (opcode == OP_JAL);
  assign is_cond = !is_jmp && (entry_i.is_branch || (opcode == OP_BRANCH));

  always_comb begin
    cond_taken = 1'b0;
    case (entry_i.funct3)
      3'b000:  cond_taken = (src1_i == src2_i);
      3'b001:  cond_taken = (src1_i != src2_i);
      3'b100:  cond_taken = ($signed(src1_i) <  $signed(src2_i));
      3'b101:  cond_taken = ($signed(src1_i) >= $signed(src2_i));
      3'b110:  cond_taken = (src1_i <  src2_i);
      3'b111:  cond_taken = (src1_i >= src2_i);
      default: cond_taken = 1'b0;
    endcase
  end

  assign actual_taken = is_jmp || (is_cond && cond_taken);
  assign taken_target = is_jalr ? ((src1_i + entry_i.imm) & 32'hFFFF_FFFE)
                                : (entry_i.pc + entry_i.imm);
  assign seq_pc       = entry_i.pc + 32'd4;
  assign next_pc      = actual_taken ? taken_target : seq_pc;
  assign mispredict   = (actual_taken != pred_taken_i) ||
                        (actual_taken && pred_taken_i && (taken_target != pred_target_i));
  assign resolve      = issue_valid_i && entry_i.valid && !flush_i;
  assign upd_idx      = entry_i.pc[BHT_IDX_W+1:2];

  // Outputs are single-cycle pulses: anything not refreshed by a resolve returns to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_o  <= 1'b0;
      target_pc_o   <= '0;
      recover_tag_o <= '0;
      wb_o          <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else begin
      mispredict_o  <= 1'b0;
      target_pc_o   <= '0;
      recover_tag_o <= '0;
      wb_o          <= '0;
      if (resolve) begin
        wb_o.valid   <= 1'b1;
        wb_o.rob_tag <= entry_i.rob_tag;
        wb_o.rd_used <= entry_i.rd_used;
        wb_o.prd     <= entry_i.rd_used ? entry_i.prd : '0;
        wb_o.data    <= (is_jmp && entry_i.rd_used) ? seq_pc : '0;
        if (mispredict) begin
          mispredict_o  <= 1'b1;
          target_pc_o   <= next_pc;
          recover_tag_o <= entry_i.rob_tag;
        end
        if (is_cond) begin
          if (cond_taken && bht[upd_idx] != 2'b11) begin
            bht[upd_idx] <= bht[upd_idx] + 2'b01;
          end else if (!cond_taken && bht[upd_idx] != 2'b00) begin
            bht[upd_idx] <= bht[upd_idx] - 2'b01;
          end
        end
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (resolve) begin
      if (is_cond && br_cnt != 32'hFFFF_FFFF) br_cnt <= br_cnt + 32'd1;
      if (mispredict && mp_cnt != 32'hFFFF_FFFF) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign perf_br_cnt_o = br_cnt;
  assign perf_mp_cnt_o = mp_cnt;
`else
  assign perf_br_cnt_o = '0;
  assign perf_mp_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bru_predict.sv
// Directed plus randomized bench for bru_predict against a behavioural model
// (per-index saturating counters and plain-arithmetic branch rules).
module tb_bru_predict;
  import bru_pkg::*;

  localparam int N = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_i;
  logic [31:0]       lookup_pc_i;
  logic              lookup_taken_o;
  logic              issue_valid_i;
  rs_entry_t         entry_i;
  xlen_t             src1_i;
  xlen_t             src2_i;
  logic              pred_taken_i;
  logic [31:0]       pred_target_i;
  logic              mispredict_o;
  logic [31:0]       target_pc_o;
  logic [ROB_W-1:0]  recover_tag_o;
  wb_pkt_t           wb_o;
  logic [31:0]       perf_br_cnt_o;
  logic [31:0]       perf_mp_cnt_o;

  always #5 clk = ~clk;

  bru_predict #(.BHT_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .lookup_pc_i(lookup_pc_i), .lookup_taken_o(lookup_taken_o),
    .issue_valid_i(issue_valid_i), .entry_i(entry_i),
    .src1_i(src1_i), .src2_i(src2_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .mispredict_o(mispredict_o), .target_pc_o(target_pc_o),
    .recover_tag_o(recover_tag_o), .wb_o(wb_o),
    .perf_br_cnt_o(perf_br_cnt_o), .perf_mp_cnt_o(perf_mp_cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int bht_m [N];
  int unsigned br_m = 0;
  int unsigned mp_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_br();
`ifdef BRU_PERF_CNT_EN
    return br_m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mp();
`ifdef BRU_PERF_CNT_EN
    return mp_m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic pred_of(input logic [31:0] pc);
    return bht_m[(pc / 4) % N] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) bht_m[i] = 1;
    br_m = 0;
    mp_m = 0;
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] pc);
    lookup_pc_i = pc;
    #1;
    check(tag, 32'(lookup_taken_o), 32'(pred_of(pc)));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mp"}, 32'(mispredict_o), 32'd0);
    check({tag, "_tgt"}, target_pc_o, 32'd0);
    check({tag, "_tag"}, 32'(recover_tag_o), 32'd0);
    check({tag, "_wb"}, 32'(wb_o), 32'd0);
    check({tag, "_pbr"}, perf_br_cnt_o, exp_br());
    check({tag, "_pmp"}, perf_mp_cnt_o, exp_mp());
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    check_idle(tag);
  endtask

  // kind: 0 cond branch, 1 JAL via flag, 2 JALR, 3 JAL via opcode only
  task automatic do_resolve(input string tag, input int kind, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [2:0] f3,
                            input logic [31:0] s1, input logic [31:0] s2,
                            input logic pred, input logic [31:0] ptgt,
                            input logic rdu, input logic [5:0] prd, input logic [5:0] tag_v,
                            input logic flush, input logic ev);
    rs_entry_t e;
    logic act;
    logic mp;
    logic [31:0] tgt;
    logic [31:0] npc;
    int idx;
    e = '0;
    e.valid = ev; e.pc = pc; e.imm = imm; e.funct3 = f3;
    e.rd_used = rdu; e.prd = prd; e.rob_tag = tag_v;
    case (kind)
      0: begin e.is_branch = 1'b1; e.instr = {17'h0, f3, 5'h0, 7'b1100011}; end
      1: begin e.is_jump = 1'b1; e.instr = {25'h0, 7'b1101111}; end
      2: begin e.is_jump = 1'b1; e.is_jalr = 1'b1; e.instr = {25'h0, 7'b1100111}; end
      default: e.instr = {25'h0, 7'b1101111};
    endcase
    act = 1'b0;
    tgt = pc + imm;
    if (kind == 0) begin
      case (f3)
        3'd0: act = (s1 == s2);
        3'd1: act = (s1 != s2);
        3'd4: act = ($signed(s1) <  $signed(s2));
        3'd5: act = ($signed(s1) >= $signed(s2));
        3'd6: act = (s1 <  s2);
        3'd7: act = (s1 >= s2);
        default: act = 1'b0;
      endcase
    end else begin
      act = 1'b1;
      if (kind == 2) tgt = (s1 + imm) & 32'hFFFF_FFFE;
    end
    npc = act ? tgt : pc + 32'd4;
    mp  = (act != pred) || (act && pred && (tgt != ptgt));
    idx = (pc / 4) % N;

    entry_i = e; src1_i = s1; src2_i = s2;
    pred_taken_i = pred; pred_target_i = ptgt;
    flush_i = flush; issue_valid_i = 1'b1;
    check_lookup({tag, "_lkpre"}, pc);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    if (flush || !ev) begin
      check_idle({tag, "_drop"});
    end else begin
      if (kind == 0) begin
        br_m++;
        if (act && bht_m[idx] < 3) bht_m[idx]++;
        if (!act && bht_m[idx] > 0) bht_m[idx]--;
      end
      if (mp) mp_m++;
      check({tag, "_mp"}, 32'(mispredict_o), 32'(mp));
      check({tag, "_tgt"}, target_pc_o, mp ? npc : 32'd0);
      check({tag, "_rtag"}, 32'(recover_tag_o), mp ? 32'(tag_v) : 32'd0);
      check({tag, "_wbv"}, 32'(wb_o.valid), 32'd1);
      check({tag, "_wbtag"}, 32'(wb_o.rob_tag), 32'(tag_v));
      check({tag, "_wbrdu"}, 32'(wb_o.rd_used), 32'(rdu));
      check({tag, "_wbprd"}, 32'(wb_o.prd), rdu ? 32'(prd) : 32'd0);
      check({tag, "_wbdata"}, wb_o.data, (kind != 0 && rdu) ? pc + 32'd4 : 32'd0);
      check({tag, "_pbr"}, perf_br_cnt_o, exp_br());
      check({tag, "_pmp"}, perf_mp_cnt_o, exp_mp());
    end
    check_lookup({tag, "_lkpost"}, pc);
  endtask

  initial begin
    // Reset with a resolve pending: the resolve must be discarded.
    model_reset();
    rst_n = 1'b0;
    flush_i = 1'b0;
    lookup_pc_i = 32'h100;
    issue_valid_i = 1'b1;
    entry_i = '0;
    entry_i.valid = 1'b1;
    entry_i.is_branch = 1'b1;
    entry_i.pc = 32'h100;
    src1_i = 32'd1;
    src2_i = 32'd1;
    pred_taken_i = 1'b0;
    pred_target_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    rst_n = 1'b1;
    check_idle("reset");
    check("reset_lk100", 32'(lookup_taken_o), 32'd0);
    for (int i = 0; i < N; i++) check_lookup("reset_lkall", 32'(i * 4));

    do_resolve("beq_mp", 0, 32'h100, 32'h20, 3'b000, 32'd5, 32'd5, 1'b0, 32'h0,
               1'b0, 6'd0, 6'd3, 1'b0, 1'b1);
    check("beq_lk_after1", 32'(lookup_taken_o), 32'd1);
    idle_cycle("beq_hold");
    repeat (3) do_resolve("beq_tk", 0, 32'h100, 32'h20, 3'b000, 32'd5, 32'd5, 1'b1, 32'h120,
                          1'b0, 6'd0, 6'd4, 1'b0, 1'b1);
    repeat (3) do_resolve("beq_nt", 0, 32'h100, 32'h20, 3'b000, 32'd5, 32'd6, 1'b0, 32'h0,
                          1'b0, 6'd0, 6'd5, 1'b0, 1'b1);
    check("beq_lk_final", 32'(lookup_taken_o), 32'd0);

    do_resolve("bne_mp", 0, 32'h200, 32'h40, 3'b001, 32'd7, 32'd7, 1'b1, 32'h240,
               1'b0, 6'd0, 6'd6, 1'b0, 1'b1);
    do_resolve("jalr", 2, 32'h300, 32'h4, 3'b000, 32'h1001, 32'h0, 1'b1, 32'h1004,
               1'b1, 6'd9, 6'd7, 1'b0, 1'b1);
    do_resolve("flush", 0, 32'h100, 32'h20, 3'b000, 32'd5, 32'd5, 1'b0, 32'h0,
               1'b1, 6'd2, 6'd8, 1'b1, 1'b1);
    do_resolve("jal_op", 3, 32'h400, 32'hFFFF_FFF0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h123,
               1'b1, 6'd11, 6'd9, 1'b0, 1'b1);

    for (int it = 0; it < 300; it++) begin
      int kind;
      logic [31:0] pc, imm, s1, s2, ptgt;
      logic [2:0] f3;
      kind = $urandom_range(0, 3);
      pc   = 32'($urandom_range(0, 255)) * 32'd4;
      imm  = (32'($urandom_range(0, 4095)) * 32'd2) - 32'd4096;
      f3   = 3'($urandom_range(0, 7));
      s1   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
      s2   = ($urandom_range(0, 2) == 0) ? s1 : (($urandom_range(0, 1) == 1) ? $urandom
                                                   : 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) ptgt = $urandom;
      else if (kind == 2) ptgt = (s1 + imm) & 32'hFFFF_FFFE;
      else ptgt = pc + imm;
      do_resolve("rand", kind, pc, imm, f3, s1, s2, 1'($urandom_range(0, 1)), ptgt,
                 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
    end

    // Reset mid-run with a resolve in flight; counters and BHT return to defaults.
    rst_n = 1'b0;
    issue_valid_i = 1'b1;
    entry_i.valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    check_idle("rst2");
    for (int i = 0; i < N; i++) check_lookup("rst2_lk", 32'(i * 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
